// File: rtl/altro_bus_pkg.sv
//------------------------------------------------------------------------------
// Module   : altro_bus_pkg
// Desc     : Shared types and constants for the ALTRO bus master slice.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package altro_bus_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ADDR      = 3'd1,
        S_WAIT_ACK  = 3'd2,
        S_REL       = 3'd3,
        S_WAIT_TRSF = 3'd4,
        S_COLLECT   = 3'd5,
        S_DONE      = 3'd6
    } state_t;

    localparam logic [1:0] c_ERR_OK   = 2'b00;
    localparam logic [1:0] c_ERR_ACK  = 2'b01;
    localparam logic [1:0] c_ERR_TRSF = 2'b10;
    localparam logic [1:0] c_ERR_OVF  = 2'b11;

    localparam int c_BD_W     = 40;
    localparam int c_FIELD_W  = 20;
    localparam int c_WORDS_W  = 12;
    localparam int c_ADDR_MSB = 39;
    localparam int c_ADDR_LSB = 20;
    localparam int c_DATA_MSB = 19;
    localparam int c_DATA_LSB = 0;

    function automatic logic [c_BD_W-1:0] bd_pack(input logic [c_FIELD_W-1:0] addr,
                                                  input logic [c_FIELD_W-1:0] data);
        logic [c_BD_W-1:0] res;
        res = '0;
        res[c_ADDR_MSB:c_ADDR_LSB] = addr;
        res[c_DATA_MSB:c_DATA_LSB] = data;
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/altro_bus_master_if.sv
//------------------------------------------------------------------------------
// Module   : altro_bus_master_if
// Desc     : Command, response, readout stream and ALTRO bus signal bundle.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface altro_bus_master_if;
    import altro_bus_pkg::*;

    logic                 cmd_valid;
    logic                 cmd_ready;
    logic                 cmd_write;
    logic                 cmd_rdo;
    logic [c_FIELD_W-1:0] cmd_addr;
    logic [c_FIELD_W-1:0] cmd_data;
    logic                 rsp_valid;
    logic [c_FIELD_W-1:0] rsp_data;
    logic [1:0]           rsp_err;
    logic [c_WORDS_W-1:0] rsp_words;
    logic                 out_valid;
    logic [c_BD_W-1:0]    out_data;
    logic                 out_last;
    logic                 cstb;
    logic                 write;
    logic [c_BD_W-1:0]    bd_out;
    logic                 bd_oe;
    logic [c_BD_W-1:0]    bd_in;
    logic                 ackn;
    logic                 dstb;
    logic                 trsf;

    modport master (
        input  cmd_valid, cmd_write, cmd_rdo, cmd_addr, cmd_data,
        input  bd_in, ackn, dstb, trsf,
        output cmd_ready, rsp_valid, rsp_data, rsp_err, rsp_words,
        output out_valid, out_data, out_last,
        output cstb, write, bd_out, bd_oe
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_rdo, cmd_addr, cmd_data,
        output bd_in, ackn, dstb, trsf,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err, rsp_words,
        input  out_valid, out_data, out_last,
        input  cstb, write, bd_out, bd_oe
    );

endinterface

`default_nettype wire

// File: rtl/altro_rdo_collector.sv
//------------------------------------------------------------------------------
// Module   : altro_rdo_collector
// Desc     : One-word hold buffer turning dstb-strobed bus words into a stream.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module altro_rdo_collector
    import altro_bus_pkg::*;
#(
    parameter int MAX_WORDS = 4095
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    input  wire logic                 i_clear,
    input  wire logic                 i_enable,
    input  wire logic                 i_dstb,
    input  wire logic                 i_trsf,
    input  wire logic [c_BD_W-1:0]    i_bd_in,
    output logic                      o_out_valid,
    output logic [c_BD_W-1:0]         o_out_data,
    output logic                      o_out_last,
    output logic [c_WORDS_W-1:0]      o_words,
    output logic                      o_overflow,
    output logic                      o_done
);

    localparam logic [c_WORDS_W-1:0] c_MAX = c_WORDS_W'(MAX_WORDS);

    logic [c_BD_W-1:0]    r_buf;
    logic                 r_full;
    logic                 r_end_seen;
    logic [c_WORDS_W-1:0] r_count;
    logic                 r_ovf;
    logic                 r_out_valid;
    logic                 r_out_last;
    logic [c_BD_W-1:0]    r_out_data;

    logic w_end;
    logic w_strobe;
    logic w_room;
    logic w_capture;

    // Only the first cycle with trsf low may still carry a word.
    assign w_end     = i_enable & ~i_trsf;
    assign w_strobe  = i_enable & i_dstb & ~r_end_seen;
    assign w_room    = (r_count < c_MAX);
    assign w_capture = w_strobe & w_room;
    assign o_done    = w_end & ~w_capture;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_buf       <= '0;
            r_full      <= 1'b0;
            r_end_seen  <= 1'b0;
            r_count     <= '0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_data  <= '0;
        end else begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            if (w_strobe && !w_room) begin
                r_ovf <= 1'b1;
            end
            if (w_end) begin
                r_end_seen <= 1'b1;
            end
            if (w_capture) begin
                if (r_full) begin
                    r_out_valid <= 1'b1;
                    r_out_data  <= r_buf;
                end
                r_buf   <= i_bd_in;
                r_full  <= 1'b1;
                r_count <= r_count + 1'b1;
            end else if (w_end && r_full) begin
                r_out_valid <= 1'b1;
                r_out_last  <= 1'b1;
                r_out_data  <= r_buf;
                r_full      <= 1'b0;
            end
        end
    end

    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_out_data;
    assign o_out_last  = r_out_last;
    assign o_words     = r_count;
    assign o_overflow  = r_ovf;

endmodule

`default_nettype wire

// File: rtl/altro_bus_master.sv
//------------------------------------------------------------------------------
// Module   : altro_bus_master
// Desc     : RCU-side ALTRO bus initiator: register read/write and readout.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module altro_bus_master
    import altro_bus_pkg::*;
#(
    parameter int ACK_TIMEOUT  = 64,
    parameter int TRSF_TIMEOUT = 1024,
    parameter int MAX_WORDS    = 4095
) (
    input  wire logic           rcu_clk,
    input  wire logic           reset,
    altro_bus_master_if.master  bus
);

    localparam int c_TMO_MAX = (ACK_TIMEOUT > TRSF_TIMEOUT) ? ACK_TIMEOUT : TRSF_TIMEOUT;
    localparam int c_TMO_W   = (c_TMO_MAX > 1) ? $clog2(c_TMO_MAX) : 1;
    localparam logic [c_TMO_W-1:0] c_ACK_LIM  = c_TMO_W'(ACK_TIMEOUT - 1);
    localparam logic [c_TMO_W-1:0] c_TRSF_LIM = c_TMO_W'(TRSF_TIMEOUT - 1);

    state_t               r_state;
    state_t               w_state_next;
    logic                 r_ackn;
    logic                 r_dstb;
    logic                 r_trsf;
    logic [c_BD_W-1:0]    r_bd_in;
    logic [c_TMO_W-1:0]   r_tmo_cnt;
    logic                 r_wr;
    logic                 r_rdo;
    logic [c_FIELD_W-1:0] r_addr;
    logic [c_FIELD_W-1:0] r_data;
    logic [c_FIELD_W-1:0] r_rsp_data;
    logic [1:0]           r_err;

    logic                 w_accept;
    logic                 w_ack_tmo;
    logic                 w_trsf_tmo;
    logic                 w_col_en;
    logic                 w_col_done;
    logic                 w_col_ovf;
    logic [c_WORDS_W-1:0] w_col_words;

    assign w_accept = bus.cmd_valid & (r_state == S_IDLE);
    assign w_col_en = (r_state == S_COLLECT);

    always_ff @(posedge rcu_clk) begin
        if (reset) begin
            r_ackn  <= 1'b0;
            r_dstb  <= 1'b0;
            r_trsf  <= 1'b0;
            r_bd_in <= '0;
        end else begin
            r_ackn  <= bus.ackn;
            r_dstb  <= bus.dstb;
            r_trsf  <= bus.trsf;
            r_bd_in <= bus.bd_in;
        end
    end

    always_ff @(posedge rcu_clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_ack_tmo    = 1'b0;
        w_trsf_tmo   = 1'b0;
        case (r_state)
            S_IDLE:      if (w_accept) w_state_next = S_ADDR;
            S_ADDR:      w_state_next = S_WAIT_ACK;
            S_WAIT_ACK: begin
                if (r_ackn) begin
                    w_state_next = S_REL;
                end else if (r_tmo_cnt == c_ACK_LIM) begin
                    w_state_next = S_DONE;
                    w_ack_tmo    = 1'b1;
                end
            end
            S_REL: begin
                if (!r_ackn) begin
                    w_state_next = r_rdo ? S_WAIT_TRSF : S_DONE;
                end else if (r_tmo_cnt == c_ACK_LIM) begin
                    w_state_next = S_DONE;
                    w_ack_tmo    = 1'b1;
                end
            end
            S_WAIT_TRSF: begin
                if (r_trsf) begin
                    w_state_next = S_COLLECT;
                end else if (r_tmo_cnt == c_TRSF_LIM) begin
                    w_state_next = S_DONE;
                    w_trsf_tmo   = 1'b1;
                end
            end
            S_COLLECT:   if (w_col_done) w_state_next = S_DONE;
            S_DONE:      w_state_next = S_IDLE;
            default:     w_state_next = S_IDLE;
        endcase
    end

    // Counter restarts on every state change so each wait gets a full budget.
    always_ff @(posedge rcu_clk) begin
        if (reset || (w_state_next != r_state)) begin
            r_tmo_cnt <= '0;
        end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end

    always_ff @(posedge rcu_clk) begin
        if (reset) begin
            r_wr       <= 1'b0;
            r_rdo      <= 1'b0;
            r_addr     <= '0;
            r_data     <= '0;
            r_rsp_data <= '0;
            r_err      <= c_ERR_OK;
        end else if (w_accept) begin
            r_wr       <= bus.cmd_write | bus.cmd_rdo;
            r_rdo      <= bus.cmd_rdo;
            r_addr     <= bus.cmd_addr;
            r_data     <= (bus.cmd_write | bus.cmd_rdo) ? bus.cmd_data : '0;
            r_rsp_data <= '0;
            r_err      <= c_ERR_OK;
        end else begin
            if ((r_state == S_WAIT_ACK) && r_ackn && !r_wr) begin
                r_rsp_data <= r_bd_in[c_DATA_MSB:c_DATA_LSB];
            end
            if (w_ack_tmo) begin
                r_err <= c_ERR_ACK;
            end else if (w_trsf_tmo) begin
                r_err <= c_ERR_TRSF;
            end
        end
    end

    altro_rdo_collector #(
        .MAX_WORDS (MAX_WORDS)
    ) u_collector (
        .clk         (rcu_clk),
        .rst         (reset),
        .i_clear     (w_accept),
        .i_enable    (w_col_en),
        .i_dstb      (r_dstb),
        .i_trsf      (r_trsf),
        .i_bd_in     (r_bd_in),
        .o_out_valid (bus.out_valid),
        .o_out_data  (bus.out_data),
        .o_out_last  (bus.out_last),
        .o_words     (w_col_words),
        .o_overflow  (w_col_ovf),
        .o_done      (w_col_done)
    );

    // Reads release the bus right after the address phase so the responder can drive.
    assign bus.cmd_ready = (r_state == S_IDLE);
    assign bus.cstb      = (r_state == S_ADDR) || (r_state == S_WAIT_ACK);
    assign bus.write     = bus.cstb & r_wr;
    assign bus.bd_oe     = (r_state == S_ADDR) || ((r_state == S_WAIT_ACK) && r_wr);
    assign bus.bd_out    = bus.bd_oe ? bd_pack(r_addr, r_data) : '0;
    assign bus.rsp_valid = (r_state == S_DONE);
    assign bus.rsp_data  = r_rsp_data;
    assign bus.rsp_err   = w_col_ovf ? c_ERR_OVF : r_err;
    assign bus.rsp_words = w_col_words;

endmodule

`default_nettype wire

// File: tb/tb_altro_bus_master.sv
//------------------------------------------------------------------------------
// Module   : tb_altro_bus_master
// Desc     : Randomized scoreboard bench with a behavioural ALTRO responder.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_altro_bus_master;

    localparam int TB_MAX = 10;

    typedef struct {
        logic [19:0] data;
        logic [1:0]  err;
        logic [11:0] words;
    } rsp_t;

    typedef struct {
        logic [39:0] data;
        logic        last;
    } out_t;

    logic rcu_clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;
    rsp_t rsp_q[$];
    out_t out_q[$];

    altro_bus_master_if bus();

    altro_bus_master #(
        .ACK_TIMEOUT  (64),
        .TRSF_TIMEOUT (1024),
        .MAX_WORDS    (TB_MAX)
    ) dut (
        .rcu_clk (rcu_clk),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 rcu_clk = ~rcu_clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: pops an expectation whenever the DUT presents an output.
    initial begin
        forever begin
            @(negedge rcu_clk);
            if (!reset) begin
                if (bus.rsp_valid) begin
                    if (rsp_q.size() == 0) begin
                        chk("rsp_unexpected", bus.rsp_valid, 1'b0);
                    end else begin
                        rsp_t e;
                        e = rsp_q.pop_front();
                        chk("rsp_data", bus.rsp_data, e.data);
                        chk("rsp_err", bus.rsp_err, e.err);
                        chk("rsp_words", bus.rsp_words, e.words);
                    end
                end
                if (bus.out_valid) begin
                    if (out_q.size() == 0) begin
                        chk("out_unexpected", bus.out_valid, 1'b0);
                    end else begin
                        out_t o;
                        o = out_q.pop_front();
                        chk("out_data", bus.out_data, o.data);
                        chk("out_last", bus.out_last, o.last);
                    end
                end
            end
        end
    end

    task automatic push_rsp(input logic [19:0] d, input logic [1:0] e, input int w);
        rsp_t r;
        r.data  = d;
        r.err   = e;
        r.words = 12'(w);
        rsp_q.push_back(r);
    endtask

    task automatic push_out(input logic [39:0] d, input logic l);
        out_t o;
        o.data = d;
        o.last = l;
        out_q.push_back(o);
    endtask

    task automatic issue(input logic wr, input logic rdo, input logic [19:0] a, input logic [19:0] d);
        int t = 0;
        while (!bus.cmd_ready && t < 2000) begin
            @(negedge rcu_clk);
            t++;
        end
        chk("cmd_ready_wait", bus.cmd_ready, 1'b1);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_rdo   = rdo;
        bus.cmd_addr  = a;
        bus.cmd_data  = d;
        @(negedge rcu_clk);
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'($urandom);
        bus.cmd_addr  = 20'($urandom);
        bus.cmd_data  = 20'($urandom);
    endtask

    task automatic wait_cstb();
        int t = 0;
        while (!bus.cstb && t < 10) begin
            @(negedge rcu_clk);
            t++;
        end
        chk("cstb_addr", bus.cstb, 1'b1);
    endtask

    // Responder: acks after dly cycles, then drops ackn once cstb is released.
    task automatic ack_phase(input logic wr, input logic [19:0] a, input logic [19:0] d,
                             input logic [19:0] rd, input int dly);
        logic [39:0] exp;
        exp = {a, (wr ? d : 20'h0)};
        wait_cstb();
        chk("addr_bd_out", bus.bd_out, exp);
        chk("addr_bd_oe", bus.bd_oe, 1'b1);
        chk("addr_write", bus.write, wr);
        repeat (dly) begin
            @(negedge rcu_clk);
            chk("wait_cstb", bus.cstb, 1'b1);
            chk("wait_bd_oe", bus.bd_oe, wr);
            if (wr) chk("wait_bd_out", bus.bd_out, exp);
        end
        bus.ackn  = 1'b1;
        bus.bd_in = {20'($urandom), rd};
        @(negedge rcu_clk);
        chk("ack_cstb_hold", bus.cstb, 1'b1);
        chk("ack_bd_oe", bus.bd_oe, wr);
        @(negedge rcu_clk);
        chk("rel_cstb", bus.cstb, 1'b0);
        chk("rel_bd_oe", bus.bd_oe, 1'b0);
        chk("rel_write", bus.write, 1'b0);
        bus.ackn  = 1'b0;
        bus.bd_in = {$urandom, 8'($urandom)};
    endtask

    task automatic ack_never();
        int cnt = 0;
        wait_cstb();
        while (bus.cstb && cnt < 200) begin
            cnt++;
            @(negedge rcu_clk);
        end
        chk("ack_tmo_cstb_window", ((cnt >= 64) && (cnt <= 66)), 1'b1);
        chk("ack_tmo_bd_oe", bus.bd_oe, 1'b0);
    endtask

    // Readout model: the first TB_MAX words survive, the last survivor carries out_last.
    task automatic rdo_phase(input int n, input logic tog, input logic seq, input int max_gap);
        int   kept;
        logic [63:0] rnd;
        logic [39:0] w;
        kept = (n < TB_MAX) ? n : TB_MAX;
        push_rsp(20'h0, (n > TB_MAX) ? 2'b11 : 2'b00, kept);
        repeat (3) @(negedge rcu_clk);
        bus.trsf = 1'b1;
        repeat (2) @(negedge rcu_clk);
        for (int i = 0; i < n; i++) begin
            rnd = {$urandom, $urandom};
            w   = seq ? 40'(i + 1) : rnd[39:0];
            if (i < kept) push_out(w, (i == kept - 1));
            repeat ($urandom_range(0, max_gap)) @(negedge rcu_clk);
            bus.dstb  = 1'b1;
            bus.bd_in = w;
            if (tog && (i == n - 1)) bus.trsf = 1'b0;
            @(negedge rcu_clk);
            bus.dstb  = 1'b0;
        end
        if (!(tog && n > 0)) begin
            repeat ($urandom_range(0, 2)) @(negedge rcu_clk);
            bus.trsf = 1'b0;
        end
    endtask

    task automatic wait_rsp();
        int t = 0;
        while (rsp_q.size() != 0 && t < 3000) begin
            @(negedge rcu_clk);
            t++;
        end
        chk("rsp_pending", rsp_q.size(), 0);
        @(negedge rcu_clk);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [19:0] a;
        logic [19:0] d;
        logic [19:0] rd;
        int          kind;

        reset         = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_rdo   = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_data  = '0;
        bus.bd_in     = '0;
        bus.ackn      = 1'b0;
        bus.dstb      = 1'b0;
        bus.trsf      = 1'b0;
        repeat (3) @(negedge rcu_clk);
        chk("rst_cmd_ready", bus.cmd_ready, 1'b1);
        chk("rst_cstb", bus.cstb, 1'b0);
        chk("rst_bd_oe", bus.bd_oe, 1'b0);
        chk("rst_bd_out", bus.bd_out, 40'h0);
        chk("rst_write", bus.write, 1'b0);
        chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
        chk("rst_rsp_err", bus.rsp_err, 2'b00);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        reset = 1'b0;
        @(negedge rcu_clk);

        // Directed write and read
        push_rsp(20'h0, 2'b00, 0);
        issue(1'b1, 1'b0, 20'h0A123, 20'h5A5A5);
        ack_phase(1'b1, 20'h0A123, 20'h5A5A5, 20'h0, 3);
        wait_rsp();

        push_rsp(20'h00ABC, 2'b00, 0);
        issue(1'b0, 1'b0, 20'h00040, 20'hFFFFF);
        ack_phase(1'b0, 20'h00040, 20'hFFFFF, 20'h00ABC, 2);
        wait_rsp();

        // Responder silent
        push_rsp(20'h0, 2'b01, 0);
        issue(1'b1, 1'b0, 20'h12345, 20'h6789A);
        ack_never();
        wait_rsp();

        // Readout of 8 sequential words
        issue(1'b0, 1'b1, 20'h00001, 20'h00002);
        ack_phase(1'b1, 20'h00001, 20'h00002, 20'h0, 1);
        rdo_phase(8, 1'b0, 1'b1, 1);
        wait_rsp();

        // Readout without trsf
        push_rsp(20'h0, 2'b10, 0);
        issue(1'b0, 1'b1, 20'h00003, 20'h00004);
        ack_phase(1'b1, 20'h00003, 20'h00004, 20'h0, 0);
        wait_rsp();

        // Overflow with final word coinciding with trsf fall, then an empty readout
        issue(1'b0, 1'b1, 20'h00005, 20'h00006);
        ack_phase(1'b1, 20'h00005, 20'h00006, 20'h0, 1);
        rdo_phase(12, 1'b1, 1'b0, 1);
        wait_rsp();
        issue(1'b0, 1'b1, 20'h00007, 20'h00008);
        ack_phase(1'b1, 20'h00007, 20'h00008, 20'h0, 1);
        rdo_phase(0, 1'b0, 1'b0, 0);
        wait_rsp();

        // Reset during COLLECT after three words: only the two pushed-out words appear
        issue(1'b0, 1'b1, 20'h00009, 20'h0000A);
        ack_phase(1'b1, 20'h00009, 20'h0000A, 20'h0, 1);
        repeat (3) @(negedge rcu_clk);
        bus.trsf = 1'b1;
        repeat (2) @(negedge rcu_clk);
        for (int i = 0; i < 3; i++) begin
            if (i < 2) push_out(40'(64'hA0 + i), 1'b0);
            bus.dstb  = 1'b1;
            bus.bd_in = 40'(64'hA0 + i);
            @(negedge rcu_clk);
            bus.dstb  = 1'b0;
            @(negedge rcu_clk);
        end
        repeat (3) @(negedge rcu_clk);
        chk("pre_rst_out_drained", out_q.size(), 0);
        reset = 1'b1;
        @(negedge rcu_clk);
        chk("mid_rst_cstb", bus.cstb, 1'b0);
        chk("mid_rst_bd_oe", bus.bd_oe, 1'b0);
        chk("mid_rst_out_valid", bus.out_valid, 1'b0);
        chk("mid_rst_cmd_ready", bus.cmd_ready, 1'b1);
        chk("mid_rst_rsp_valid", bus.rsp_valid, 1'b0);
        bus.trsf = 1'b0;
        reset    = 1'b0;
        repeat (2) @(negedge rcu_clk);

        push_rsp(20'h0, 2'b00, 0);
        issue(1'b1, 1'b0, 20'h0BEEF, 20'h0CAFE);
        ack_phase(1'b1, 20'h0BEEF, 20'h0CAFE, 20'h0, 2);
        wait_rsp();

        // Randomized mix
        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 2);
            a    = 20'($urandom);
            d    = 20'($urandom);
            rd   = 20'($urandom);
            if (kind == 0) begin
                push_rsp(20'h0, 2'b00, 0);
                issue(1'b1, 1'b0, a, d);
                ack_phase(1'b1, a, d, rd, $urandom_range(0, 6));
            end else if (kind == 1) begin
                push_rsp(rd, 2'b00, 0);
                issue(1'b0, 1'b0, a, d);
                ack_phase(1'b0, a, d, rd, $urandom_range(0, 6));
            end else begin
                issue(1'($urandom), 1'b1, a, d);
                ack_phase(1'b1, a, d, rd, $urandom_range(0, 6));
                rdo_phase($urandom_range(0, 14), 1'($urandom), 1'b0, 3);
            end
            wait_rsp();
        end

        repeat (4) @(negedge rcu_clk);
        chk("end_rsp_pending", rsp_q.size(), 0);
        chk("end_out_pending", out_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/altro_bus_master.md
Name: altro_bus_master

Overview:
- RCU-side initiator for the ALTRO front-end bus. Issues register writes and reads (cstb/write/bd address-data phase, ackn handshake) toward a front-end responder such as the TRU fake ALTRO.
- Also runs readout transactions: waits for trsf and collects dstb-strobed 40-bit words into a stream.
- Used in the TRU test fixture and the board controller to exercise and read back the front-end emulation without a real RCU.

Parameters:
- ACK_TIMEOUT, 64, max rcu_clk cycles to wait for each ackn edge.
- TRSF_TIMEOUT, 1024, max cycles from readout-command completion to trsf assertion.
- MAX_WORDS, 4095, readout words beyond this count are dropped and flagged.

Ports:
- rcu_clk  in  1  bus clock; all logic single-domain.
- reset  in  1  synchronous, active-high.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high in IDLE only.
- cmd_write  in  1  1=write, 0=read.
- cmd_rdo  in  1  readout command; treated as a write, then collect.
- cmd_addr  in  20  driven on bd[39:20].
- cmd_data  in  20  driven on bd[19:0] for writes.
- rsp_valid  out  1  one-cycle pulse, transaction done.
- rsp_data  out  20  read data; 0 for writes.
- rsp_err  out  2  00 ok, 01 ackn timeout, 10 trsf timeout, 11 word overflow.
- rsp_words  out  12  readout word count.
- out_valid  out  1  readout word strobe.
- out_data  out  40  readout word.
- out_last  out  1  marks the final word of a readout.
- cstb  out  1  control strobe.
- write  out  1  bus direction qualifier.
- bd_out  out  40  bus drive value.
- bd_oe  out  1  bus drive enable; tristate is done at top level.
- bd_in  in  40  bus sampled value.
- ackn  in  1  responder acknowledge.
- dstb  in  1  data strobe, rcu_clk-synchronous.
- trsf  in  1  transfer window.

Behaviour:
- Reset: all outputs 0 except cmd_ready=1. FSM goes to IDLE. Counters and buffer are cleared. Reset mid-transaction aborts immediately; no rsp is issued.
- Inputs ackn, dstb, trsf and bd_in are registered once before use. All latencies below include this one-cycle register.
- IDLE: when cmd_valid & cmd_ready, latch the command and go to ADDR.
- ADDR (1 cycle): cstb=1, write=cmd_write|cmd_rdo, bd_oe=1, bd_out={addr,data}. For a read, bd_out[19:0]=0.
- Next state from ADDR: WAIT_ACK.
- WAIT_ACK: hold cstb.
  - Write: keep driving the bus.
  - Read: bd_oe=0 from this state on.
  - On ackn=1, capture bd_in[19:0] into rsp_data (reads only) and go to REL.
  - If the timeout counter reaches ACK_TIMEOUT, end with err=01.
- REL: cstb=0, bd_oe=0, write=0. Wait for ackn=0, with the same timeout.
  - Plain command: go to DONE.
  - cmd_rdo: go to WAIT_TRSF.
- WAIT_TRSF: wait for trsf=1; TRSF_TIMEOUT violation gives err=10. Then go to COLLECT.
- COLLECT:
  - Each cycle with dstb=1 captures bd_in into a 1-word hold buffer. If the buffer was already full, its old contents are emitted first: out_valid=1, out_last=0.
  - When trsf falls, flush the buffer with out_last=1 and go to DONE.
  - trsf falls with zero words: no out_valid; rsp_words=0; err=00.
  - dstb=1 in the same cycle trsf falls: that word is captured, then emitted as last.
  - Word count saturates at MAX_WORDS. Further words are dropped and err=11; collection continues until trsf falls.
- DONE: rsp_valid pulse for 1 cycle, then IDLE. cmd_ready rises the cycle after.
- Any timeout: release cstb and bd_oe in the same cycle, then DONE.
- cmd_valid while not ready: ignored, and must be held by the host.
- Timeout counter: width is clog2 of the largest timeout. It resets on every state entry.

Decomposition:
- Shared package altro_bus_pkg holds:
  - FSM state enum (IDLE, ADDR, WAIT_ACK, REL, WAIT_TRSF, COLLECT, DONE).
  - rsp_err code constants.
  - Address field constants: bd[39:20] address, bd[19:0] data.
- One sub-module: altro_rdo_collector. It owns the hold buffer, word counter, overflow flag and out_* generation, enabled by the COLLECT state.

Test Plan:
- Write addr=0x0A123, data=0x5A5A5 with a responder acking after 3 cycles:
  - bd_out=0x0A1235A5A5 with bd_oe=1 throughout WAIT_ACK.
  - rsp_valid with err=00, rsp_data=0.
  - cstb low 1 cycle after the registered ackn.
- Read addr=0x00040, responder drives bd_in[19:0]=0x00ABC with ackn:
  - bd_oe=0 from WAIT_ACK on.
  - rsp_data=0x00ABC, err=00.
- Responder never acks: cstb drops after ACK_TIMEOUT=64 cycles, rsp_err=01, cmd_ready returns.
- Readout with trsf held for 8 dstb pulses carrying 0x0000000001..0x0000000008:
  - 8 out_valid pulses in order, out_last only on word 8.
  - rsp_words=8, err=00.
- Readout with no trsf: rsp_err=10 after 1024 cycles; no out_valid.
- Reset asserted in COLLECT after 3 words:
  - next cycle cstb=0, bd_oe=0, out_valid=0, cmd_ready=1, and no rsp_valid.
  - A following write completes normally.
